// File: rtl/daq_sequencer.sv
// Periodic scan controller: a Wishbone-programmed timer starts scans that walk
// the enabled channels through a req/ack handshake and queue tagged samples.
module daq_sequencer #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int NCH     = 8,
    parameter int CHW     = 3,
    parameter int SW      = 16,
    parameter int FIFO_AW = 4
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    input  logic [aw-1:0]  wb_adr_i,
    input  logic [dw-1:0]  wb_dat_i,
    input  logic [3:0]     wb_sel_i,
    input  logic           wb_we_i,
    input  logic           wb_cyc_i,
    input  logic           wb_stb_i,
    output logic [dw-1:0]  wb_dat_o,
    output logic           wb_ack_o,
    output logic           wb_err_o,
    output logic           smp_req_o,
    output logic [CHW-1:0] smp_ch_o,
    input  logic           smp_ack_i,
    input  logic [SW-1:0]  smp_dat_i,
    output logic           irq_o
);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(1) << FIFO_AW;

    typedef enum logic [1:0] {IDLE, WAIT, REQ, DONE} state_t;

    state_t state_q, state_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0] scan_q, scan_d, chmask_q, chmask_d;
    logic en_q, en_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d, en_prev_q;
    logic [7:0] thresh_q, thresh_d;
    logic [31:0] period_q, period_d, cnt_q, cnt_d, dat_q, dat_d, rdat, word;
    logic ovr_q, ovr_d, und_q, und_d, ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count_q, count_d;
    logic [31:0] mem_q [2**FIFO_AW];

    logic wb_req, wr, rd, mapped, flush, pop_req, push_req, pop_ok, push_ok;
    logic full, empty, tick, busy, en_clr, next_vld;
    logic [CHW-1:0] first_ch, next_ch;
    logic [2:0] off;
    logic unused_adr;

    assign unused_adr = ^{wb_adr_i[aw-1:5], wb_adr_i[1:0]};

    assign off      = wb_adr_i[4:2];
    assign wb_req   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign wr       = wb_req & wb_we_i;
    assign rd       = wb_req & ~wb_we_i;
    assign mapped   = (off <= 3'd4);
    assign flush    = wr & (off == 3'd0) & wb_sel_i[0] & wb_dat_i[2];
    assign pop_req  = rd & (off == 3'd4);
    assign push_req = (state_q == REQ) & smp_ack_i;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop_ok   = pop_req & ~empty;
    // Popping a full FIFO frees the slot the simultaneous push lands in.
    assign push_ok  = push_req & ~flush & (~full | pop_ok);
    assign tick     = en_q & en_prev_q & (cnt_q == '0);
    assign busy     = (state_q == REQ) || (state_q == DONE);
    assign word     = {8'(ptr_q), 8'h00, 16'(smp_dat_i)};

    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        next_vld = 1'b0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (chmask_q[i]) first_ch = CHW'(i);
            if (scan_q[i] && (i > int'(ptr_q))) begin
                next_ch  = CHW'(i);
                next_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        scan_d  = scan_q;
        en_clr  = 1'b0;
        case (state_q)
            IDLE: if (en_q) state_d = WAIT;
            WAIT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else if (tick && (chmask_q != '0)) begin
                    state_d = REQ;
                    ptr_d   = first_ch;
                    scan_d  = chmask_q;
                end
            end
            REQ: begin
                if (smp_ack_i) begin
                    if (!en_q)        state_d = IDLE;
                    else if (next_vld) ptr_d  = next_ch;
                    else              state_d = DONE;
                end
            end
            DONE: begin
                if (oneshot_q) begin
                    en_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = en_q ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        thresh_d  = thresh_q;
        period_d  = period_q;
        chmask_d  = chmask_q;
        ovr_d     = ovr_q;
        und_d     = und_q;
        if (wr) begin
            case (off)
                3'd0: begin
                    if (wb_sel_i[0]) begin
                        en_d      = wb_dat_i[0];
                        oneshot_d = wb_dat_i[1];
                        irq_en_d  = wb_dat_i[3];
                    end
                    if (wb_sel_i[1]) thresh_d = wb_dat_i[15:8];
                end
                3'd1: begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_i[b]) period_d[8*b +: 8] = wb_dat_i[8*b +: 8];
                end
                3'd2: begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel_i[b])
                            for (int k = 8*b; k < 8*b+8; k++)
                                if (k < NCH) chmask_d[k] = wb_dat_i[k];
                end
                3'd3: begin
                    if (wb_sel_i[0] && wb_dat_i[1]) ovr_d = 1'b0;
                    if (wb_sel_i[0] && wb_dat_i[2]) und_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (en_clr) en_d = 1'b0;
        if (push_req && !flush && full && !pop_ok) ovr_d = 1'b1;
        if (pop_req && empty) und_d = 1'b1;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        end

        cnt_d = cnt_q;
        if (en_q && !en_prev_q)   cnt_d = period_q;
        else if (en_q)            cnt_d = (cnt_q == '0) ? period_q : cnt_q - 32'd1;

        rdat = '0;
        case (off)
            3'd0: begin
                rdat[0]    = en_q;
                rdat[1]    = oneshot_q;
                rdat[3]    = irq_en_q;
                rdat[15:8] = thresh_q;
            end
            3'd1: rdat = period_q;
            3'd2: rdat[NCH-1:0] = chmask_q;
            3'd3: begin
                rdat[0] = busy;
                rdat[1] = ovr_q;
                rdat[2] = und_q;
                rdat[FIFO_AW+8:8] = count_q;
            end
            3'd4: if (pop_ok) rdat = mem_q[rd_ptr_q];
            default: ;
        endcase
        dat_d = (rd && mapped) ? rdat : '0;
        ack_d = wb_req & mapped;
        err_d = wb_req & ~mapped;
        irq_d = irq_en_q & ((32'(count_q) >= 32'(thresh_q)) | ovr_q);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            scan_q    <= '0;
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            thresh_q  <= '0;
            period_q  <= '0;
            chmask_q  <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            und_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            scan_q    <= scan_d;
            en_q      <= en_d;
            en_prev_q <= en_q;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            thresh_q  <= thresh_d;
            period_q  <= period_d;
            chmask_q  <= chmask_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            und_q     <= und_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= word;
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign smp_req_o = (state_q == REQ);
    assign smp_ch_o  = ptr_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_daq_sequencer.sv
// Bench for daq_sequencer: register table, scan timing, FIFO corner cases,
// mid-scan disable, oneshot, flush and asynchronous reset.
module tb_daq_sequencer;
    logic        wb_clk, wb_rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic        smp_req_o, smp_ack_i, irq_o;
    logic [2:0]  smp_ch_o;
    logic [15:0] smp_dat_i;

    daq_sequencer dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .smp_req_o(smp_req_o), .smp_ch_o(smp_ch_o), .smp_ack_i(smp_ack_i),
        .smp_dat_i(smp_dat_i), .irq_o(irq_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [25];
    int          checks = 0, failures = 0, cyc_n = 0, src_age = 0;
    logic        src_auto = 1'b0;
    logic [15:0] src_dat = 16'h0100;
    logic [31:0] sbq [$];
    int          log_cyc [$];
    int          log_ch [$];
    logic [31:0] rdv, exp_w;
    logic [1:0]  tm;
    logic        saw_req;
    int          n;

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) cyc_n <= cyc_n + 1;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", nm, act, exp);
        end
    endtask

    function automatic void sb_push(input logic [31:0] w);
        if (sbq.size() < 16) sbq.push_back(w);
    endfunction

    // Sample source: acks each request on its second visible cycle.
    initial begin
        smp_ack_i = 1'b0;
        smp_dat_i = '0;
        forever begin
            @(posedge wb_clk); #1;
            if (src_auto && wb_rst_n) begin
                if (smp_ack_i) begin
                    smp_ack_i = 1'b0;
                    src_age   = 0;
                end else if (smp_req_o) begin
                    if (src_age == 0) begin
                        log_cyc.push_back(cyc_n);
                        log_ch.push_back(int'(smp_ch_o));
                    end
                    src_age++;
                    if (src_age >= 2) begin
                        src_dat++;
                        smp_dat_i = src_dat;
                        smp_ack_i = 1'b1;
                        sb_push({8'(smp_ch_o), 8'h00, src_dat});
                    end
                end
            end else begin
                src_age = 0;
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic [1:0] term);
        int  k;
        logic got;
        @(negedge wb_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        k = 0; got = 1'b0; rdat = '0; term = 2'b00;
        while (!got && k < 8) begin
            @(posedge wb_clk); #1;
            k++;
            if (wb_ack_o || wb_err_o) begin
                got  = 1'b1;
                rdat = wb_dat_o;
                term = {wb_ack_o, wb_err_o};
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        chk("wb_latency", k, 1);
        @(posedge wb_clk); #1;
        chk("wb_pulse", 32'({wb_ack_o, wb_err_o}), 0);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        logic [1:0]  t;
        wb_xfer(1'b1, adr, dat, sel, d, t);
        chk("wr_term", 32'(t), 32'h2);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
        logic [1:0] t;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, d, t);
        chk("rd_term", 32'(t), 32'h2);
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (!smp_req_o && k < 60) begin
            @(posedge wb_clk); #1;
            k++;
        end
        chk(nm, 32'(smp_req_o), 1);
    endtask

    task automatic man_ack(input logic [15:0] d);
        @(negedge wb_clk);
        chk("man_ack_req", 32'(smp_req_o), 1);
        smp_dat_i = d;
        smp_ack_i = 1'b1;
        sb_push({8'(smp_ch_o), 8'h00, d});
        @(posedge wb_clk); #1;
        smp_ack_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        logic [31:0] d, e;
        int cnt = sbq.size();
        for (int i = 0; i < cnt; i++) begin
            wb_rd(32'h10, d);
            e = sbq.pop_front();
            chk(nm, d, e);
        end
    endtask

    initial begin
        wb_rst_n = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;

        tbl[0]  = '{1'b0, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 32'h08, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h4,        1'b0};
        tbl[6]  = '{1'b0, 32'h14, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 32'h1C, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b1, 32'h18, 32'hFF,       4'hF, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h04, 32'h12345678, 4'hF, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h2, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h1234FF78, 1'b0};
        tbl[12] = '{1'b1, 32'h08, 32'h1FF,      4'hF, 32'h0,        1'b0};
        tbl[13] = '{1'b0, 32'h08, 32'h0,        4'hF, 32'hFF,       1'b0};
        tbl[14] = '{1'b1, 32'h00, 32'hAB0C,     4'hF, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 32'h00, 32'h0,        4'hF, 32'hAB08,     1'b0};
        tbl[16] = '{1'b1, 32'h00, 32'h0000FF00, 4'h1, 32'h0,        1'b0};
        tbl[17] = '{1'b0, 32'h00, 32'h0,        4'hF, 32'hAB00,     1'b0};
        tbl[18] = '{1'b1, 32'h10, 32'hDEAD,     4'hF, 32'h0,        1'b0};
        tbl[19] = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h4,        1'b0};
        tbl[20] = '{1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        tbl[21] = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[22] = '{1'b1, 32'h00, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[23] = '{1'b1, 32'h04, 32'h0,        4'hF, 32'h0,        1'b0};
        tbl[24] = '{1'b1, 32'h08, 32'h0,        4'hF, 32'h0,        1'b0};

        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(posedge wb_clk); #1;
        chk("rst_outputs", 32'({smp_req_o, irq_o, wb_ack_o, wb_err_o, smp_ch_o}), 0);

        // Register map, byte lanes, error offsets, underflow/W1C.
        foreach (tbl[i]) begin
            wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rdv, tm);
            chk($sformatf("t1_term_%0d", i), 32'(tm), tbl[i].exp_err ? 32'h1 : 32'h2);
            if (!tbl[i].we && !tbl[i].exp_err) chk($sformatf("t1_rd_%0d", i), rdv, tbl[i].exp);
        end

        // Periodic scans of ch0 and ch2.
        wb_wr(32'h04, 32'd9, 4'hF);
        wb_wr(32'h08, 32'h05, 4'hF);
        log_cyc.delete(); log_ch.delete();
        src_auto = 1'b1;
        wb_wr(32'h00, 32'h1, 4'hF);
        repeat (45) @(posedge wb_clk);
        wb_wr(32'h00, 32'h0, 4'hF);
        repeat (20) @(posedge wb_clk);
        #1;
        chk("t2_nreq", 32'(log_ch.size() >= 6), 1);
        for (int i = 0; i < log_ch.size(); i++)
            chk("t2_ch_order", log_ch[i], (i % 2 == 0) ? 0 : 2);
        for (int i = 2; i < log_ch.size(); i += 2)
            chk("t2_period", log_cyc[i] - log_cyc[i-2], 10);
        chk("t2_sb_cnt", 32'(sbq.size() >= 6), 1);
        drain("t2_data");

        // Fill beyond depth: count saturates, overrun, irq.
        wb_wr(32'h00, 32'h2009, 4'hF);
        repeat (150) @(posedge wb_clk);
        #1;
        chk("t3_irq_ovr", 32'(irq_o), 1);
        wb_rd(32'h0C, rdv);
        chk("t3_status", rdv & 32'hFFFF_FFFE, 32'h1002);
        wb_wr(32'h00, 32'h2008, 4'hF);
        repeat (20) @(posedge wb_clk);
        src_auto = 1'b0;
        wb_wr(32'h0C, 32'h2, 4'h1);
        wb_rd(32'h0C, rdv);
        chk("t3_ovr_w1c", rdv, 32'h1000);
        chk("t3_irq_off", 32'(irq_o), 0);
        wb_wr(32'h00, 32'h1008, 4'hF);
        repeat (2) @(posedge wb_clk);
        #1;
        chk("t3_irq_thresh", 32'(irq_o), 1);

        // Push and pop on a full FIFO in the same cycle, oneshot scan.
        wb_wr(32'h08, 32'h01, 4'hF);
        wb_wr(32'h04, 32'd3, 4'hF);
        wb_wr(32'h00, 32'h100B, 4'hF);
        wait_req("t4_req");
        @(negedge wb_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10; wb_sel_i = 4'hF;
        smp_dat_i = 16'hABCD; smp_ack_i = 1'b1;
        @(posedge wb_clk); #1;
        smp_ack_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        chk("t4_pop_ack", 32'(wb_ack_o), 1);
        exp_w = sbq.pop_front();
        chk("t4_pop_data", wb_dat_o, exp_w);
        sbq.push_back(32'h0000ABCD);
        @(posedge wb_clk); #1;
        wb_rd(32'h0C, rdv);
        chk("t4_full_status", rdv, 32'h1000);
        wb_rd(32'h00, rdv);
        chk("t4_oneshot_ctrl", rdv, 32'h100A);
        drain("t4_drain");
        wb_rd(32'h10, rdv);
        chk("t4_empty_read", rdv, 0);
        wb_rd(32'h0C, rdv);
        chk("t4_underflow", rdv, 32'h4);
        wb_wr(32'h0C, 32'h4, 4'h1);
        wb_rd(32'h0C, rdv);
        chk("t4_und_w1c", rdv, 0);

        // Disable while ch1 of 0x07 is outstanding.
        wb_wr(32'h08, 32'h07, 4'hF);
        wb_wr(32'h00, 32'h1, 4'hF);
        wait_req("t5_req");
        chk("t5_ch0", 32'(smp_ch_o), 0);
        man_ack(16'h1111);
        chk("t5_ch1_req", 32'({smp_req_o, smp_ch_o}), 32'h9);
        wb_wr(32'h00, 32'h0, 4'hF);
        chk("t5_ch1_hold", 32'({smp_req_o, smp_ch_o}), 32'h9);
        man_ack(16'h2222);
        chk("t5_req_drop", 32'(smp_req_o), 0);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge wb_clk); #1;
            if (smp_req_o) saw_req = 1'b1;
        end
        chk("t5_no_ch2", 32'(saw_req), 0);
        wb_rd(32'h0C, rdv);
        chk("t5_status", rdv, 32'h0200);
        drain("t5_data");

        // Oneshot: exactly one scan, en self-clears; then flush.
        wb_wr(32'h08, 32'h05, 4'hF);
        wb_wr(32'h04, 32'd4, 4'hF);
        log_cyc.delete(); log_ch.delete();
        src_auto = 1'b1;
        wb_wr(32'h00, 32'h3, 4'hF);
        repeat (60) @(posedge wb_clk);
        #1;
        src_auto = 1'b0;
        chk("t5_os_nreq", log_ch.size(), 2);
        n = (log_ch.size() >= 2) ? log_ch[0] * 16 + log_ch[1] : -1;
        chk("t5_os_chs", n, 2);
        wb_rd(32'h00, rdv);
        chk("t5_os_ctrl", rdv, 32'h2);
        wb_rd(32'h0C, rdv);
        chk("t5_os_count", rdv, 32'h0200);
        wb_wr(32'h00, 32'h4, 4'h1);
        sbq.delete();
        wb_rd(32'h0C, rdv);
        chk("t5_flush_status", rdv, 0);
        wb_rd(32'h00, rdv);
        chk("t5_flush_ctrl", rdv, 0);

        // Asynchronous reset in the middle of a request.
        wb_wr(32'h08, 32'h03, 4'hF);
        wb_wr(32'h04, 32'd20, 4'hF);
        wb_wr(32'h00, 32'h1, 4'hF);
        wait_req("t6_req");
        man_ack(16'h5555);
        chk("t6_mid_req", 32'(smp_req_o), 1);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(smp_req_o), 0);
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        sbq.delete();
        wb_rd(32'h0C, rdv);
        chk("t6_status", rdv, 0);
        wb_rd(32'h00, rdv);
        chk("t6_ctrl", rdv, 0);
        wb_rd(32'h08, rdv);
        chk("t6_chmask", rdv, 0);
        repeat (30) @(posedge wb_clk);
        #1;
        chk("t6_idle", 32'({smp_req_o, irq_o}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
